id_ex_stage: RTL

- ID/EX pipeline stage of the 5-stage MIPS core, directly downstream of the decode control unit.
- Registers the decoded control bundle plus operands, PC+4, immediate and register indices into EX.
- Detects load-use hazards and inserts a one-cycle bubble while telling IF/ID to hold.
- Applies branch/jump flush and external pipeline hold, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage_pkg.sv | 46 ++++
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode definitions: opcodes, ALUOp classes, the control bundle
// carried through ID/EX, and the operand-use rules needed for hazard checks.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   branch;
        logic   jump;
        aluop_e alu_op;
    } ctrl_t;

    // Only the jumps ignore rs; rt is a source for R-type, branches and stores.
    function automatic logic uses_rs(input logic [5:0] opcode);
        return (opcode != OP_J) && (opcode != OP_JAL);
    endfunction

    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_R_TYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)    || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage, with pipeline
// control (flush, hold, stall) and the bubble statistics counter.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [5:0]        id_opcode, id_funct;
    logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
    logic              id_MemRead, id_MemWrite, id_Branch, id_Jump;
    logic [1:0]        id_ALUOp;
    logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              flush, hold;

    logic              ex_valid;
    logic [5:0]        ex_opcode, ex_funct;
    logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
    logic              ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0]        ex_ALUOp;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic              stall_if;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_opcode, id_funct, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOp, id_pc4, id_rs_data,
               id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
        input  ex_valid, ex_opcode, ex_funct, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, stall_if, bubble_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOp, id_pc4, id_rs_data,
               id_rt_data, id_imm, id_rs, id_rt, id_rd, flush, hold,
        output ex_valid, ex_opcode, ex_funct, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, stall_if, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check: a valid load in EX whose destination rt is read by
// the instruction currently in decode.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [5:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_valid,
    output logic             luh
);
    logic rs_hit, rt_hit;

    always_comb begin
        rs_hit = uses_rs(id_opcode) && (id_rs == ex_rt);
        rt_hit = uses_rt(id_opcode) && (id_rt == ex_rt);
        // A load into $0 produces nothing to wait for.
        luh    = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid && (rs_hit || rt_hit);
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold control
// and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    ctrl_t             id_ctrl, ctrl_p1;
    logic              vld_p1;
    logic [5:0]        opcode_p1, funct_p1;
    logic [DATA_W-1:0] pc4_p1, rs_data_p1, rt_data_p1, imm_p1;
    logic [REG_W-1:0]  rs_p1, rt_p1, rd_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              luh, insert_bubble, count_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

    // Invalid decode slots carry no side effects into EX.
    always_comb begin
        id_ctrl = '0;
        if (bus.id_valid) begin
            id_ctrl.reg_dst    = bus.id_RegDst;
            id_ctrl.alu_src    = bus.id_ALUSrc;
            id_ctrl.mem_to_reg = bus.id_MemtoReg;
            id_ctrl.reg_write  = bus.id_RegWrite;
            id_ctrl.mem_read   = bus.id_MemRead;
            id_ctrl.mem_write  = bus.id_MemWrite;
            id_ctrl.branch     = bus.id_Branch;
            id_ctrl.jump       = bus.id_Jump;
            id_ctrl.alu_op     = aluop_e'(bus.id_ALUOp);
        end
    end

    id_ex_stage_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_opcode   (bus.id_opcode),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_valid    (bus.id_valid),
        .ex_mem_read (ctrl_p1.mem_read),
        .ex_rt       (rt_p1),
        .ex_valid    (vld_p1),
        .luh         (luh)
    );

    assign count_bubble  = luh && !bus.flush && !bus.hold;
    assign insert_bubble = bus.flush || count_bubble;
    assign bus.stall_if  = count_bubble && !reset;

    // ID -> EX boundary: flush beats hold beats load-use beats advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_p1    <= '0;
            vld_p1     <= 1'b0;
            opcode_p1  <= '0;
            funct_p1   <= '0;
            pc4_p1     <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else if (insert_bubble) begin
            ctrl_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (!bus.hold) begin
            ctrl_p1    <= id_ctrl;
            vld_p1     <= bus.id_valid;
            opcode_p1  <= bus.id_opcode;
            funct_p1   <= bus.id_funct;
            pc4_p1     <= bus.id_pc4;
            rs_data_p1 <= bus.id_rs_data;
            rt_data_p1 <= bus.id_rt_data;
            imm_p1     <= bus.id_imm;
            rs_p1      <= bus.id_rs;
            rt_p1      <= bus.id_rt;
            rd_p1      <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else if (count_bubble) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign bus.ex_valid    = vld_p1;
    assign bus.ex_opcode   = opcode_p1;
    assign bus.ex_funct    = funct_p1;
    assign bus.ex_RegDst   = ctrl_p1.reg_dst;
    assign bus.ex_ALUSrc   = ctrl_p1.alu_src;
    assign bus.ex_MemtoReg = ctrl_p1.mem_to_reg;
    assign bus.ex_RegWrite = ctrl_p1.reg_write;
    assign bus.ex_MemRead  = ctrl_p1.mem_read;
    assign bus.ex_MemWrite = ctrl_p1.mem_write;
    assign bus.ex_Branch   = ctrl_p1.branch;
    assign bus.ex_Jump     = ctrl_p1.jump;
    assign bus.ex_ALUOp    = ctrl_p1.alu_op;
    assign bus.ex_pc4      = pc4_p1;
    assign bus.ex_rs_data  = rs_data_p1;
    assign bus.ex_rt_data  = rt_data_p1;
    assign bus.ex_imm      = imm_p1;
    assign bus.ex_rs       = rs_p1;
    assign bus.ex_rt       = rt_p1;
    assign bus.ex_rd       = rd_p1;
    assign bus.bubble_cnt  = cnt_p1;
endmodule
